// File: rtl/cla_multicycle_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_multicycle_adder
// Description : Sequential WIDTH-bit adder built around a single 4-bit
//               carry-lookahead slice. Operands are accepted through a
//               valid/ready handshake and one nibble is added per cycle,
//               LSB nibble first, with a registered carry chaining the
//               nibbles. The result is offered through a valid/ready
//               output handshake.
//
// Parameters  : WIDTH  operand/sum width, a multiple of 4 and >= 4
//
// Ports       : clk        clock, rising edge
//               rst_n      asynchronous active-low reset
//               in_valid   operands a/b/cin valid
//               in_ready   block can accept operands (IDLE only)
//               a, b       WIDTH-bit operands
//               cin        carry into bit 0
//               out_valid  sum/cout valid (DONE only)
//               out_ready  consumer accepts result
//               sum        registered WIDTH-bit sum (modulo 2^WIDTH)
//               cout       carry out of bit WIDTH-1
//               ovf        signed overflow, present only with CLA_OVF_EN
//
// Build macro : CLA_OVF_EN  adds the ovf port and its register
//
// Revision    : 1.0  initial release
// ============================================================================
module cla_multicycle_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB  = WIDTH / 4;
    // Index width; a single-nibble build still needs a one-bit counter.
    localparam int c_iw = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [c_iw-1:0] c_last = c_iw'(NIB - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [c_iw-1:0]  r_idx;

    // Bit offset of the current nibble: index * 4.
    logic [c_iw+1:0]  w_base;
    logic [3:0]       w_an;
    logic [3:0]       w_bn;
    logic [3:0]       w_p;
    logic [3:0]       w_g;
    logic [4:0]       w_c;
    logic [3:0]       w_s;

    assign w_base = {r_idx, 2'b00};
    assign w_an   = r_a[w_base +: 4];
    assign w_bn   = r_b[w_base +: 4];

    assign w_p = w_an ^ w_bn;
    assign w_g = w_an & w_bn;

    // Every carry is a flat sum of products of p/g and the incoming carry,
    // so no carry depends on another within the slice.
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & r_carry);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & r_carry);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_c[4] = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);

    assign w_s = w_p ^ w_c[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= c_calc;
                    end
                end
                c_calc: begin
                    // Only the current nibble of the sum is written; the
                    // others keep whatever they held before.
                    r_sum[w_base +: 4] <= w_s;
                    r_carry            <= w_c[4];
                    r_idx              <= r_idx + 1'b1;
                    if (r_idx == c_last) begin
                        r_cout  <= w_c[4];
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

`ifdef CLA_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == c_calc) && (r_idx == c_last)) begin
            r_ovf <= w_c[3] ^ w_c[4];
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_done);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule
`default_nettype wire
